// File: rtl/flush_issue_ctrl.sv
// Flush initiator: fixed-priority pick among flush sources, one-cycle flush pulse,
// then a fixed drain wait and a bounded wait for the pipeline drain acknowledge.
module flush_issue_ctrl #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*PC_W-1:0] src_target,
  output logic [NUM_SRC-1:0]      src_grant,
  output logic                    flush_req,
  output logic [PC_W-1:0]         flush_target,
  output logic [NUM_SRC-1:0]      flush_src,
  input  logic                    flush_ack,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_ACK} state_e;

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);
  localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [3:0]          drain_cnt_q, drain_cnt_d;
  logic [7:0]          to_cnt_q, to_cnt_d;
  logic                early_ack_q, early_ack_d;
  logic                flush_req_q, flush_req_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [PC_W-1:0]     flush_target_q, flush_target_d;
  logic [NUM_SRC-1:0]  flush_src_q, flush_src_d;

  logic                found;
  logic [NUM_SRC-1:0]  pick;
  logic [PC_W-1:0]     pick_target;

  // Lowest set index wins.
  always_comb begin
    found       = 1'b0;
    pick        = '0;
    pick_target = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && !found) begin
        found       = 1'b1;
        pick[i]     = 1'b1;
        pick_target = src_target[i*PC_W +: PC_W];
      end
    end
  end

  // Grant is suppressed while reset is asserted so no source sees a phantom acceptance.
  assign src_grant = (state_q == IDLE && reset_n) ? pick : '0;

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    to_cnt_d       = to_cnt_q;
    early_ack_d    = early_ack_q;
    flush_req_d    = 1'b0;
    flush_target_d = flush_target_q;
    flush_src_d    = flush_src_q;
    timeout_err_d  = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = ISSUE;
          flush_req_d    = 1'b1;
          flush_target_d = pick_target;
          flush_src_d    = pick;
        end
      end
      ISSUE: begin
        drain_cnt_d = DRAIN_LD;
        to_cnt_d    = '0;
        early_ack_d = 1'b0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (flush_ack) early_ack_d = 1'b1;
        drain_cnt_d = drain_cnt_q - 4'd1;
        if (drain_cnt_q <= 4'd1) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (flush_ack || early_ack_q) begin
          state_d = IDLE;
        end else if (to_cnt_q >= TO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      drain_cnt_q    <= '0;
      to_cnt_q       <= '0;
      early_ack_q    <= 1'b0;
      flush_req_q    <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      flush_target_q <= '0;
      flush_src_q    <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      to_cnt_q       <= to_cnt_d;
      early_ack_q    <= early_ack_d;
      flush_req_q    <= flush_req_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      flush_target_q <= flush_target_d;
      flush_src_q    <= flush_src_d;
    end
  end

  assign flush_req    = flush_req_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign flush_target = flush_target_q;
  assign flush_src    = flush_src_q;

endmodule

// File: doc/flush_issue_ctrl.md
Name: flush_issue_ctrl

Overview:
- Initiator side of the pipeline flush path. Collects flush causes from NUM_SRC requesters (branch mispredict, exception, external), picks one by fixed priority, and captures its redirect target.
- Issues a single-cycle flush pulse into the flush pipeline, then waits for the pipelined flush to propagate and for the pipeline's drain acknowledge.
- Presents exactly one flush transaction at a time and reports a timeout if the acknowledge never arrives.

Parameters:
- NUM_SRC, 4, number of flush request sources; index 0 has the highest priority.
- PC_W, 32, width of the redirect target.
- DRAIN_CYCLES, 2, fixed propagation delay of the downstream flush pipeline in cycles; must be 1..15.
- ACK_TIMEOUT, 15, maximum number of cycles spent in WAIT_ACK before an error is flagged; must be 1..255.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, synchronous active-low reset.
- src_valid, input, NUM_SRC, per-source flush request; level-held until granted.
- src_target, input, NUM_SRC*PC_W, per-source redirect target; source i occupies bits [i*PC_W +: PC_W].
- src_grant, output, NUM_SRC, one-hot acceptance pulse.
- flush_req, output, 1, single-cycle flush pulse driven into the flush pipeline input.
- flush_target, output, PC_W, captured redirect target; stable from ISSUE until return to IDLE.
- flush_src, output, NUM_SRC, one-hot id of the source being serviced; stable for the same interval as flush_target.
- flush_ack, input, 1, pipeline drain-complete acknowledge.
- busy, output, 1, high in every state except IDLE.
- timeout_err, output, 1, sticky error flag; cleared only by reset.

Behaviour:
- Reset (reset_n low at a clk edge):
  - State returns to IDLE.
  - src_grant, flush_req, flush_src, flush_target, busy and timeout_err all reset to 0.
  - Internal counters clear.
  - Reset overrides everything, including a flush in progress; no pulse is emitted on the reset cycle.
- States: IDLE, ISSUE, DRAIN, WAIT_ACK.
- IDLE:
  - If any src_valid bit is set, the lowest set index i wins. src_grant[i] is driven combinationally high in that same cycle.
  - At the clock edge, src_target[i] is captured into flush_target, flush_src is set to one-hot i, and the state moves to ISSUE.
  - Losing sources receive no grant and must keep src_valid asserted.
- ISSUE:
  - flush_req = 1 for exactly this one cycle.
  - Drain counter loads DRAIN_CYCLES; next state is DRAIN.
- DRAIN:
  - Counter decrements once per cycle; the state moves to WAIT_ACK when the count reaches 1, so DRAIN lasts exactly DRAIN_CYCLES cycles.
  - If flush_ack arrives during DRAIN it is an early ack: it is latched, and WAIT_ACK is then exited on its first cycle.
- WAIT_ACK:
  - When flush_ack (or the latched early ack) is seen, the next state is IDLE.
  - Otherwise the timeout counter increments each cycle. When it reaches ACK_TIMEOUT, timeout_err is set and the state moves to IDLE.
- src_grant is 0 outside IDLE. New requests are held off, with no queuing, until IDLE.
- Back-to-back flushes: the earliest re-grant is the first IDLE cycle after the ack.
  - Minimum spacing between flush_req pulses is 1 (ISSUE) + DRAIN_CYCLES + 1 (WAIT_ACK) + 1 (IDLE grant) cycles.
- flush_ack asserted while in IDLE or ISSUE is ignored.
- busy is a registered decode of state (state != IDLE).
- Latency from src_valid to flush_req: 1 cycle, with the grant in cycle N and flush_req in cycle N+1.

Test Plan:
- Reset sequence:
  - Stimulus: hold reset_n=0 for 3 cycles with src_valid=4'b1111.
  - Required: no grant and all outputs 0 throughout; grant[0] appears on the first cycle after release.
- Single flush:
  - Stimulus: src_valid=4'b0100, target 0x0000_1A40; flush_ack pulsed 3 cycles after flush_req.
  - Required: grant=4'b0100 in cycle N, flush_req in cycle N+1, flush_target=0x1A40, flush_src=4'b0100, busy high N+1..N+4, IDLE again at N+5.
- Priority:
  - Stimulus: src_valid=4'b1010 with distinct targets.
  - Required: source 1 is serviced first; source 3 is granted in the first IDLE cycle after the ack.
- Early ack:
  - Stimulus: flush_ack pulsed in the first DRAIN cycle.
  - Required: WAIT_ACK lasts exactly 1 cycle; timeout_err stays 0.
- Timeout:
  - Stimulus: ACK_TIMEOUT=15, flush_ack never asserted.
  - Required: timeout_err rises after 15 WAIT_ACK cycles, stays high, and the controller returns to IDLE and accepts the next request.
- Reset mid-flush:
  - Stimulus: drop reset_n during DRAIN.
  - Required: all outputs 0 on the next cycle; a subsequent request is serviced normally.
